// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage (radix-2 shift-add / restoring).
// Optional MULDIV_FAST_MUL_EN: single-cycle 33x33 multiplier for MUL*; divide stays iterative.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [4:0]  M_OP_BASE = 5'b01000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       aluop_in,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hold_in,
    output logic [WIDTH-1:0] result_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [5:0]       LastIter = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IntMin   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state, w_state_nxt;
    logic [5:0]       r_count, w_count_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic             r_neg_res, w_neg_res_nxt;
    logic             r_neg_rem, w_neg_rem_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic [WIDTH-1:0] r_opnd, w_opnd_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;

    logic [4:0]       w_op_off;
    logic [2:0]       w_op;
    logic             w_in_range, w_is_m, w_accept, w_op_div;
    logic             w_a_signed, w_b_signed, w_sign_a, w_sign_b;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_fast_res;
    logic             w_b_zero, w_div_ovf, w_fast_div;

    assign w_op_off   = aluop_in - M_OP_BASE;
    assign w_in_range = (aluop_in >= M_OP_BASE) && (w_op_off < 5'd8);
    assign w_is_m     = start && w_in_range;
    assign w_accept   = w_is_m && !flush;
    assign w_op       = w_op_off[2:0];
    assign w_op_div   = w_op[2];

    // Op order: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
    assign w_a_signed = w_op[2] ? !w_op[0] : (w_op != 3'd3);
    assign w_b_signed = w_op[2] ? !w_op[0] : !w_op[1];
    assign w_sign_a   = w_a_signed && operand_a[WIDTH-1];
    assign w_sign_b   = w_b_signed && operand_b[WIDTH-1];
    assign w_mag_a    = w_sign_a ? -operand_a : operand_a;
    assign w_mag_b    = w_sign_b ? -operand_b : operand_b;

    assign w_b_zero   = (operand_b == '0);
    assign w_div_ovf  = w_op_div && !w_op[0] && (operand_a == IntMin) && (&operand_b);
    assign w_fast_div = w_op_div && (w_b_zero || w_div_ovf);
    assign w_fast_res = w_b_zero ? (w_op[1] ? operand_a : '1) : (w_op[1] ? '0 : IntMin);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0]     w_fm_a, w_fm_b;
    logic signed [2*WIDTH-1:0] w_fm_prod;
    logic [WIDTH-1:0]          w_fm_res;

    assign w_fm_a    = {w_sign_a, operand_a};
    assign w_fm_b    = {w_sign_b, operand_b};
    assign w_fm_prod = (2*WIDTH)'(w_fm_a) * (2*WIDTH)'(w_fm_b);
    assign w_fm_res  = (w_op == 3'd0) ? w_fm_prod[WIDTH-1:0] : w_fm_prod[2*WIDTH-1:WIDTH];
`endif

    // One iteration step: hi/lo form the product shifter or the remainder/quotient pair.
    logic [WIDTH:0]   w_sum, w_shift;
    logic [WIDTH-1:0] w_sub, w_iter_hi, w_iter_lo;
    logic             w_ge;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_sub   = w_shift[WIDTH-1:0] - r_opnd;

    always_comb begin
        if (r_op[2]) begin
            w_iter_hi = w_ge ? w_sub : w_shift[WIDTH-1:0];
            w_iter_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_iter_hi = w_sum[WIDTH:1];
            w_iter_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0]   w_quo, w_rem, w_final;

    assign w_prod   = {w_iter_hi, w_iter_lo};
    assign w_prod_s = r_neg_res ? -w_prod : w_prod;
    assign w_quo    = r_neg_res ? -w_iter_lo : w_iter_lo;
    assign w_rem    = r_neg_rem ? -w_iter_hi : w_iter_hi;

    always_comb begin
        case (r_op)
            3'd0:             w_final = w_prod_s[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: w_final = w_prod_s[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       w_final = w_quo;
            default:          w_final = w_rem;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_op_nxt      = r_op;
        w_neg_res_nxt = r_neg_res;
        w_neg_rem_nxt = r_neg_rem;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_opnd_nxt    = r_opnd;
        w_result_nxt  = r_result;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_op_nxt      = w_op;
                    w_count_nxt   = '0;
                    w_neg_res_nxt = w_sign_a ^ w_sign_b;
                    w_neg_rem_nxt = w_sign_a;
                    w_hi_nxt      = '0;
                    w_lo_nxt      = w_op_div ? w_mag_a : w_mag_b;
                    w_opnd_nxt    = w_op_div ? w_mag_b : w_mag_a;
                    if (w_fast_div) begin
                        w_state_nxt  = StDone;
                        w_result_nxt = w_fast_res;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!w_op_div) begin
                        w_state_nxt  = StDone;
                        w_result_nxt = w_fm_res;
                    end
`endif
                    else begin
                        w_state_nxt = StRun;
                    end
                end
            end
            StRun: begin
                w_hi_nxt    = w_iter_hi;
                w_lo_nxt    = w_iter_lo;
                w_count_nxt = r_count + 6'd1;
                if (r_count == LastIter) begin
                    w_state_nxt  = StDone;
                    w_result_nxt = w_final;
                end
            end
            StDone: begin
                if (!hold_in) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (flush) begin
            w_state_nxt = StIdle;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_count   <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_op      <= w_op_nxt;
            r_neg_res <= w_neg_res_nxt;
            r_neg_rem <= w_neg_rem_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_opnd    <= w_opnd_nxt;
            r_result  <= w_result_nxt;
        end
    end

    // A flush must not be masked by our own stall request.
    assign busy       = ((r_state == StIdle) && w_accept) || ((r_state == StRun) && !flush);
    assign done       = (r_state == StDone) && !flush;
    assign result_out = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random RV32M ops checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

    localparam logic [4:0] MBase = 5'b01000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  aluop;
    logic [31:0] opa, opb;
    logic        flush, hold_in;
    logic [31:0] result;
    logic        busy, done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(
        .WIDTH     (32),
        .M_OP_BASE (MBase)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .aluop_in   (aluop),
        .operand_a  (opa),
        .operand_b  (opb),
        .flush      (flush),
        .hold_in    (hold_in),
        .result_out (result),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input int op, input logic [31:0] x,
                                              input logic [31:0] y);
        logic [63:0] p;
        longint      sx, sy;
        int          ix, iy, q;
        sx = $signed(x);
        sy = $signed(y);
        ix = $signed(x);
        iy = $signed(y);
        case (op)
            0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            1: begin p = sx * sy; return p[63:32]; end
            2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
            3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ix / iy;
                return q;
            end
            5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                q = ix % iy;
                return q;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input int op, input logic [31:0] x, input logic [31:0] y);
        if (op >= 4 && y == 0) return 1;
        if ((op == 4 || op == 6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (op < 4) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Runs one M-op with start held until done; optionally holds DONE for hold_cycles.
    task automatic do_op(input int op, input logic [31:0] x, input logic [31:0] y,
                         input int hold_cycles);
        logic [31:0] exp_res;
        int          lat, exp_lat;
        bit          busy_ok;
        string       tag;
        tag     = $sformatf("op%0d_%08h_%08h", op, x, y);
        exp_res = ref_model(op, x, y);
        exp_lat = exp_latency(op, x, y);
        @(posedge clk);
        #1;
        start   = 1'b1;
        aluop   = MBase + 5'(op);
        opa     = x;
        opb     = y;
        flush   = 1'b0;
        hold_in = 1'b0;
        @(negedge clk);
        check_val({tag, "_busy_accept"}, 32'(busy), 32'd1);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            hold_in = 1'($urandom_range(0, 1));
        end
        check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
        if (lat != 0) begin
            check_val({tag, "_result"}, result, exp_res);
            check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
            last_result = exp_res;
            hold_in = (hold_cycles > 0);
            for (int h = 0; h < hold_cycles; h++) begin
                @(posedge clk);
                @(negedge clk);
                check_val({tag, "_hold_done"}, 32'(done), 32'd1);
                check_val({tag, "_hold_result"}, result, exp_res);
                check_val({tag, "_hold_busy"}, 32'(busy), 32'd0);
            end
            hold_in = 1'b0;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check_val({tag, "_leave_done"}, 32'(done), 32'd0);
        end else begin
            flush = 1'b1;
            start = 1'b0;
            @(posedge clk);
            #1;
            flush   = 1'b0;
            hold_in = 1'b0;
        end
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_seen, busy_seen;
        logic [4:0] non_m [3];
        rst = 1'b1; start = 1'b0; aluop = '0; opa = '0; opb = '0; flush = 1'b0; hold_in = 1'b0;
        #12;
        check_val("reset_result", result, 32'h0);
        check_val("reset_done", 32'(done), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
        do_op(1, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(4, 32'hFFFF_FFEC, 32'd3, 0);
        do_op(6, 32'hFFFF_FFEC, 32'd3, 0);
        do_op(5, 32'd100, 32'd7, 0);
        do_op(7, 32'd100, 32'd7, 0);
        do_op(4, 32'd5, 32'd0, 0);
        do_op(7, 32'd5, 32'd0, 0);
        do_op(4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(5, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Flush mid-run: DIVU aborted after 10 iterations, then a clean DIVU.
        @(posedge clk);
        #1;
        start = 1'b1; aluop = MBase + 5'd5; opa = 32'd1000; opb = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_val("flush_busy", 32'(busy), 32'd0);
        check_val("flush_done", 32'(done), 32'd0);
        check_val("flush_result_kept", result, last_result);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check_val("flush_no_late_done", 32'(done_seen), 32'd0);
        do_op(5, 32'd9, 32'd3, 0);

        // Asynchronous reset mid-run.
        @(posedge clk);
        #1;
        start = 1'b1; aluop = MBase + 5'd4; opa = 32'd12345; opb = 32'd67;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1; start = 1'b0;
        #1;
        check_val("rst_mid_result", result, 32'h0);
        check_val("rst_mid_done", 32'(done), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check_val("rst_mid_no_residue_done", 32'(done_seen), 32'd0);
        check_val("rst_mid_no_residue_busy", 32'(busy_seen), 32'd0);

        // Hold in DONE with start still high.
        do_op(5, 32'd100, 32'd7, 3);

        // Flush together with start in IDLE is not accepted.
        @(posedge clk);
        #1;
        start = 1'b1; aluop = MBase + 5'd5; opa = 32'd50; opb = 32'd5; flush = 1'b1;
        @(negedge clk);
        check_val("flush_start_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_val("flush_start_not_run", 32'(busy), 32'd0);
        check_val("flush_start_not_done", 32'(done), 32'd0);

        // Non-M aluops, including both neighbours of the M range.
        non_m[0] = 5'd0;
        non_m[1] = MBase - 5'd1;
        non_m[2] = MBase + 5'd8;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            start = 1'b1; aluop = non_m[i]; opa = $urandom; opb = $urandom;
            done_seen = 1'b0;
            busy_seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (done) done_seen = 1'b1;
                if (busy) busy_seen = 1'b1;
                @(posedge clk);
            end
            check_val($sformatf("non_m_%0d_busy", non_m[i]), 32'(busy_seen), 32'd0);
            check_val($sformatf("non_m_%0d_done", non_m[i]), 32'(done_seen), 32'd0);
            #1;
            start = 1'b0;
        end

        for (int i = 0; i < 60; i++) begin
            do_op($urandom_range(0, 7), pick_operand(), pick_operand(),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered aluop and the forwarded operands, and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Raises a stall request while running; the stall is ORed into the pipeline-register busywait so the instruction is held in EX until the result is ready.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.
M_OP_BASE, 5'b01000, aluop code of MUL. Codes M_OP_BASE+0..+7 are, in order: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  EX holds a valid instruction
aluop_in  input  5  aluop from the ID/EX register
operand_a  input  32  rs1 value (dividend / multiplicand)
operand_b  input  32  rs2 value (divisor / multiplier)
flush  input  1  synchronous abort (branch/jump flush)
hold_in  input  1  downstream stall; pipeline will not advance
result_out  output  32  M-op result, valid while done=1
busy  output  1  stall request to the pipeline registers
done  output  1  result valid

Behaviour:
- Reset (asynchronous): state=IDLE, result_out=0, done=0, iteration counter=0, internal registers=0. Reset mid-operation aborts the operation with no residue.
- is_m = start && aluop_in in [M_OP_BASE, M_OP_BASE+7]. Non-M aluop or start=0 in IDLE: no action, busy=0.
- States:
  - IDLE: accept when is_m && !flush. Operand magnitudes and result signs are latched.
  - RUN: 32 iterations, 6-bit counter 0..31, one iteration per edge; on counter=31 go to DONE.
  - DONE: done=1, result_out stable. Leave for IDLE on the first edge with hold_in=0; stay while hold_in=1. start is ignored in DONE.
- busy = (IDLE && is_m && !flush) || RUN. busy is combinational, so the pipeline stalls in the acceptance cycle. busy=0 in DONE.
- Latency: the acceptance edge enters RUN; done=1 in the cycle after the 32nd iteration edge, i.e. 33 cycles after the acceptance cycle.
- Multiply: radix-2 shift-add on 32-bit magnitudes into a 64-bit product.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
  - Negate the 64-bit product if the signs differ.
  - Select: MUL returns bits [31:0]; the three MULH variants return bits [63:32].
- Divide: restoring, unsigned on magnitudes.
  - Signed quotient sign = sign(a) XOR sign(b); signed remainder sign = sign(a).
- Fast paths: IDLE goes directly to DONE, done in the cycle after acceptance, no RUN.
  - Divisor=0: quotient=0xFFFFFFFF, remainder=operand_a (all four div/rem ops).
  - DIV/REM with a=0x80000000, b=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- flush: highest priority after rst. Any state goes to IDLE on the next edge. done=0 and busy=0 in that cycle; result_out keeps its last value.
- flush and start in the same IDLE cycle: not accepted.
- hold_in has no effect in IDLE or RUN.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: the four multiply ops use a single-cycle combinational 33x33 signed multiplier. IDLE goes directly to DONE, done=1 in the cycle after acceptance, and busy is high only in the acceptance cycle. Divide behaviour is unchanged.
- Undefined: multiply uses the 32-iteration RUN path with the same timing as divide. No hardware multiplier is inferred.

Test Plan:
1. MUL 0x00000007 x 0xFFFFFFFD -> result_out=0xFFFFFFEB. done exactly 33 cycles after acceptance (1 with MULDIV_FAST_MUL_EN); busy high from the acceptance cycle until done.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFEC / 3 -> 0xFFFFFFFA; REM same operands -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with 33-cycle latency.
4. DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. done in the cycle after acceptance, busy only in the acceptance cycle.
5. DIVU started, flush at iteration 10 -> busy=0, done=0 next cycle. Then DIVU 9/3 -> 3 correct. Repeat with rst mid-run -> all outputs 0.
6. hold_in=1 for 3 DONE cycles with start still high -> done=1 and result_out unchanged, no restart. start with aluop=0 (ADD) in IDLE -> busy=0, done never asserted.
